// File: rtl/osd_rst_sequencer.sv
// Ordered system/CPU reset sequencer driven by SCM reset-vector requests.
// Define OSD_RST_SEQ_SYNC_EN to pass both requests through 2-flop synchronizers.
module osd_rst_sequencer #(
  parameter int unsigned SYS_HOLD_CYCLES  = 16,
  parameter int unsigned CPU_DELAY_CYCLES = 8,
  parameter int unsigned CNT_WIDTH        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sys_rst_req,
  input  logic cpu_rst_req,
  output logic sys_rst,
  output logic cpu_rst,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    SYS_ASSERT = 2'd0,
    CPU_HOLD   = 2'd1,
    IDLE       = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] SYS_LAST = CNT_WIDTH'(SYS_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CPU_LAST = CNT_WIDTH'(CPU_DELAY_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 done_next;
  logic                 sys_req;
  logic                 cpu_req;

`ifdef OSD_RST_SEQ_SYNC_EN
  logic [1:0] sys_sync;
  logic [1:0] cpu_sync;

  // Requests may come from another domain; resolve metastability before the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_sync <= 2'b00;
      cpu_sync <= 2'b00;
    end else begin
      sys_sync <= {sys_sync[0], sys_rst_req};
      cpu_sync <= {cpu_sync[0], cpu_rst_req};
    end
  end

  assign sys_req = sys_sync[1];
  assign cpu_req = cpu_sync[1];
`else
  assign sys_req = sys_rst_req;
  assign cpu_req = cpu_rst_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYS_ASSERT;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= done_next;
    end
  end

  // Every state change clears cnt, so the counter can never wrap.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    case (state)
      SYS_ASSERT: begin
        if (sys_req) begin
          cnt_next = '0;
        end else if (cnt == SYS_LAST) begin
          state_next = CPU_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      CPU_HOLD: begin
        if (sys_req) begin
          state_next = SYS_ASSERT;
          cnt_next   = '0;
        end else if (cpu_req) begin
          cnt_next = '0;
        end else if (cnt == CPU_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      IDLE: begin
        if (sys_req) begin
          state_next = SYS_ASSERT;
          cnt_next   = '0;
        end else if (cpu_req) begin
          state_next = CPU_HOLD;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = SYS_ASSERT;
        cnt_next   = '0;
      end
    endcase
  end

  assign sys_rst = (state == SYS_ASSERT);
  assign cpu_rst = (state != IDLE);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_osd_rst_sequencer.sv
// Directed self-checking bench for osd_rst_sequencer at default parameters.
// Expected outputs are packed as {sys_rst, cpu_rst, busy, done}.
module tb_osd_rst_sequencer;

`ifdef OSD_RST_SEQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst_n;
  logic sys_rst_req;
  logic cpu_rst_req;
  logic sys_rst;
  logic cpu_rst;
  logic busy;
  logic done;

  int tests_run;
  int tests_failed;

  osd_rst_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sys_rst_req(sys_rst_req),
    .cpu_rst_req(cpu_rst_req),
    .sys_rst    (sys_rst),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_n       = 1'b0;
    sys_rst_req = 1'b0;
    cpu_rst_req = 1'b0;
    repeat (3) tick();
    exp = 4'b1110;
    tests_run++;
    if ({sys_rst, cpu_rst, busy, done} !== exp) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got=%b exp=%b", {sys_rst, cpu_rst, busy, done}, exp);
    end
  endtask

  // Releases rst_n between edges; edge 1 is the first edge after release.
  task automatic test_power_on(input string name);
    logic [3:0] exp;
    rst_n = 1'b1;
    for (int i = 1; i <= 27; i++) begin
      tick();
      exp = {(i < 16), (i < 24), (i < 24), (i == 24)};
      tests_run++;
      if ({sys_rst, cpu_rst, busy, done} !== exp) begin
        tests_failed++;
        $display("[TB] FAIL %s edge=%0d got=%b exp=%b", name, i,
                 {sys_rst, cpu_rst, busy, done}, exp);
      end
    end
  endtask

  task automatic test_sys_req();
    logic [3:0] exp;
    int j;
    for (int i = 1; i <= 31 + LAT; i++) begin
      sys_rst_req = (i <= 5);
      tick();
      j = i - LAT;
      exp = {(j >= 1 && j <= 20), (j >= 1 && j <= 28), (j >= 1 && j <= 28), (j == 29)};
      tests_run++;
      if ({sys_rst, cpu_rst, busy, done} !== exp) begin
        tests_failed++;
        $display("[TB] FAIL sys_req edge=%0d got=%b exp=%b", i,
                 {sys_rst, cpu_rst, busy, done}, exp);
      end
    end
    sys_rst_req = 1'b0;
  endtask

  task automatic test_cpu_req();
    logic [3:0] exp;
    int j;
    for (int i = 1; i <= 13 + LAT; i++) begin
      cpu_rst_req = (i <= 3);
      tick();
      j = i - LAT;
      exp = {1'b0, (j >= 1 && j <= 10), (j >= 1 && j <= 10), (j == 11)};
      tests_run++;
      if ({sys_rst, cpu_rst, busy, done} !== exp) begin
        tests_failed++;
        $display("[TB] FAIL cpu_req edge=%0d got=%b exp=%b", i,
                 {sys_rst, cpu_rst, busy, done}, exp);
      end
    end
    cpu_rst_req = 1'b0;
  endtask

  // CPU request at edge 1 reaches CPU_HOLD cnt=4 after edge 5; sys pulse lands on edge 6.
  task automatic test_restart();
    logic [3:0] exp;
    int j;
    int done_seen;
    done_seen = 0;
    for (int i = 1; i <= 33 + LAT; i++) begin
      cpu_rst_req = (i == 1);
      sys_rst_req = (i == 6);
      tick();
      j = i - LAT;
      if (done) done_seen++;
      exp = {(j >= 6 && j <= 21), (j >= 1 && j <= 29), (j >= 1 && j <= 29), (j == 30)};
      tests_run++;
      if ({sys_rst, cpu_rst, busy, done} !== exp) begin
        tests_failed++;
        $display("[TB] FAIL restart edge=%0d got=%b exp=%b", i,
                 {sys_rst, cpu_rst, busy, done}, exp);
      end
    end
    sys_rst_req = 1'b0;
    cpu_rst_req = 1'b0;
    tests_run++;
    if (done_seen !== 1) begin
      tests_failed++;
      $display("[TB] FAIL restart_done_count got=%0d exp=1", done_seen);
    end
  endtask

  task automatic test_both_req();
    logic [3:0] exp;
    int j;
    for (int i = 1; i <= 35 + LAT; i++) begin
      sys_rst_req = (i <= 2);
      cpu_rst_req = (i <= 25);
      tick();
      j = i - LAT;
      exp = {(j >= 1 && j <= 17), (j >= 1 && j <= 32), (j >= 1 && j <= 32), (j == 33)};
      tests_run++;
      if ({sys_rst, cpu_rst, busy, done} !== exp) begin
        tests_failed++;
        $display("[TB] FAIL both_req edge=%0d got=%b exp=%b", i,
                 {sys_rst, cpu_rst, busy, done}, exp);
      end
    end
    sys_rst_req = 1'b0;
    cpu_rst_req = 1'b0;
  endtask

  // Reset hits SYS_ASSERT at cnt=10, then CPU_HOLD, each checked without a clock edge.
  task automatic test_rst_mid();
    logic [3:0] exp;
    exp = 4'b1110;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({sys_rst, cpu_rst, busy, done} !== exp) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_sys got=%b exp=%b", {sys_rst, cpu_rst, busy, done}, exp);
    end
    tick();
    test_power_on("rst_mid_repeat");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({sys_rst, cpu_rst, busy, done} !== exp) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_cpu got=%b exp=%b", {sys_rst, cpu_rst, busy, done}, exp);
    end
    tick();
    test_power_on("rst_mid_cpu_repeat");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_power_on("power_on");
    test_sys_req();
    test_cpu_req();
    test_restart();
    test_both_req();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
